sn74hc165_key_reader: RTL and testbench

- Reader side of the board's serial shift-register I/O. Periodically parallel-loads an external SN74HC165, shifts its N_BITS key inputs in MSB-first, debounces each bit over several scans, and emits level and one-cycle edge pulses.
- Sits beside the SN74HC595 writer in top. Its pulses replace the direct Key_plus/Key_sub edge detectors.

---
 rtl/sn74hc_pkg.sv | 21 ++
 rtl/sn74hc165_key_reader_if.sv | 20 ++
 rtl/sn74hc165_bit_debounce.sv | 60 ++++++
 rtl/sn74hc165_key_reader.sv | 128 ++++++++++++
 tb/tb_sn74hc165_key_reader.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sn74hc_pkg.sv
// Shared constants for the SN74HC165 reader and SN74HC595 writer: 12 MHz defaults,
// reader FSM encoding and the serial bit-order convention.
package sn74hc_pkg;

  localparam int unsigned DefClkDiv        = 12;
  localparam int unsigned DefScanPeriod    = 12000;
  localparam int unsigned DefDebounceScans = 10;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Both '165 and '595 move data MSB first: serial bit 0 on the wire is index N_BITS-1.
  localparam bit MsbFirst = 1'b1;

  function automatic int unsigned bit_index_width(input int unsigned n_bits);
    return (n_bits > 1) ? $clog2(n_bits) : 1;
  endfunction

endpackage

// File: rtl/sn74hc165_key_reader_if.sv
// Three-wire link between the key reader and an external SN74HC165.
interface sn74hc165_key_reader_if;

  logic SN74HC165_data;
  logic SN74HC165_clk;
  logic SN74HC165_load_n;

  modport master (
    input  SN74HC165_data,
    output SN74HC165_clk,
    output SN74HC165_load_n
  );

  modport slave (
    output SN74HC165_data,
    input  SN74HC165_clk,
    input  SN74HC165_load_n
  );

endinterface

// File: rtl/sn74hc165_bit_debounce.sv
// Per-key debouncer: the stable value changes only after DEBOUNCE_SCANS consecutive
// disagreeing scans; emits a registered level plus one-cycle press/release pulses.
module sn74hc165_bit_debounce
  import sn74hc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = DefDebounceScans
) (
  input  logic clk,
  input  logic rst_n,
  input  logic update_i,
  input  logic sample_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_SCANS - 1);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            stable_d, stable_q;
  logic            level_q, press_q, release_q;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (update_i) begin
      if (sample_i == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntLast) begin
        stable_d = sample_i;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Inputs are active-low, so the pressed level is the inverted stable value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      stable_q  <= 1'b1;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      level_q   <= ~stable_d;
      press_q   <= stable_q & ~stable_d;
      release_q <= ~stable_q & stable_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/sn74hc165_key_reader.sv
// Periodically loads and shifts an SN74HC165 (MSB first), then debounces every key
// input and reports levels, edge pulses and a per-scan done strobe.
module sn74hc165_key_reader
  import sn74hc_pkg::*;
#(
  parameter int unsigned N_BITS         = 8,
  parameter int unsigned CLK_DIV        = DefClkDiv,
  parameter int unsigned SCAN_PERIOD    = DefScanPeriod,
  parameter int unsigned DEBOUNCE_SCANS = DefDebounceScans
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sn74hc165_key_reader_if.master sr_bus,
  output logic [N_BITS-1:0]     key_level,
  output logic [N_BITS-1:0]     key_press_pulse,
  output logic [N_BITS-1:0]     key_release_pulse,
  output logic                  scan_done
);

  localparam int unsigned TimerW = $clog2(SCAN_PERIOD);
  localparam int unsigned PhaseW = $clog2(CLK_DIV);
  localparam int unsigned IdxW   = bit_index_width(N_BITS);
  localparam int unsigned Half   = CLK_DIV / 2;

  localparam logic [TimerW-1:0] TimerLast   = TimerW'(SCAN_PERIOD - 1);
  localparam logic [PhaseW-1:0] PhaseLast   = PhaseW'(CLK_DIV - 1);
  localparam logic [PhaseW-1:0] PhaseSample = PhaseW'(Half - 1);
  localparam logic [PhaseW-1:0] PhaseRise   = PhaseW'(Half);
  localparam logic [IdxW-1:0]   IdxFirst    = IdxW'(N_BITS - 1);

  logic [TimerW-1:0] timer_d, timer_q;
  logic [1:0]        state_d, state_q;
  logic [PhaseW-1:0] phase_d, phase_q;
  logic [IdxW-1:0]   idx_d, idx_q;
  logic [N_BITS-1:0] shadow_d, shadow_q;
  logic              load_n_q, cp_q;
  logic              tick;

  assign tick    = (timer_q == TimerLast);
  assign timer_d = tick ? '0 : timer_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    unique case (state_q)
      StIdle: begin
        // Ticks arriving mid-scan are dropped: only IDLE reacts to them.
        if (tick) begin
          state_d = StLoad;
          phase_d = '0;
        end
      end
      StLoad: begin
        if (phase_q == PhaseLast) begin
          state_d = StShift;
          phase_d = '0;
          idx_d   = IdxFirst;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StShift: begin
        // Q7 is captured just before CP rises, so the first sample is input H.
        if (phase_q == PhaseSample) begin
          shadow_d[idx_q] = sr_bus.SN74HC165_data;
        end
        if (phase_q == PhaseLast) begin
          phase_d = '0;
          if (idx_q == '0) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Pin drivers are registered from next-state so the '165 never sees decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q  <= '0;
      state_q  <= StIdle;
      phase_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '1;
      load_n_q <= 1'b1;
      cp_q     <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      state_q  <= state_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      load_n_q <= (state_d != StLoad);
      cp_q     <= (state_d == StShift) && (phase_d >= PhaseRise);
    end
  end

  assign sr_bus.SN74HC165_load_n = load_n_q;
  assign sr_bus.SN74HC165_clk    = cp_q;
  assign scan_done               = (state_q == StDone);

  for (genvar i = 0; i < N_BITS; i++) begin : g_bit
    sn74hc165_bit_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .update_i  (scan_done),
      .sample_i  (shadow_q[i]),
      .level_o   (key_level[i]),
      .press_o   (key_press_pulse[i]),
      .release_o (key_release_pulse[i])
    );
  end

endmodule

// File: tb/tb_sn74hc165_key_reader.sv
// Directed bench for sn74hc165_key_reader with a behavioural SN74HC165 model.
module tb_sn74hc165_key_reader;

  localparam int unsigned NBits    = 8;
  localparam int unsigned ClkDiv   = 4;
  localparam int unsigned ScanPer  = 64;
  localparam int unsigned Debounce = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sn74hc165_key_reader_if bus ();

  logic [NBits-1:0] key_level, key_press_pulse, key_release_pulse;
  logic             scan_done;

  sn74hc165_key_reader #(
    .N_BITS        (NBits),
    .CLK_DIV       (ClkDiv),
    .SCAN_PERIOD   (ScanPer),
    .DEBOUNCE_SCANS(Debounce)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sr_bus           (bus),
    .key_level        (key_level),
    .key_press_pulse  (key_press_pulse),
    .key_release_pulse(key_release_pulse),
    .scan_done        (scan_done)
  );

  // '165 model: keys are active-low pins A..H (bit 7 = H), SER tied high.
  logic [7:0] keys = 8'hFF;
  logic [7:0] sr   = 8'hFF;
  always @(negedge bus.SN74HC165_load_n or posedge bus.SN74HC165_clk) begin
    if (!bus.SN74HC165_load_n) sr <= keys;
    else                       sr <= {sr[6:0], 1'b1};
  end
  assign bus.SN74HC165_data = sr[7];

  int vectors = 0;
  int miscompares = 0;

  // Waits for scan_done, then steps to the cycle after DONE where outputs update.
  task automatic next_scan();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scan_done !== 1'b1 && n < 200);
    vectors++;
    if (scan_done !== 1'b1) begin
      miscompares++;
      $display("FAIL scan_timeout: scan_done=%b after %0d cycles, required 1", scan_done, n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if (bus.SN74HC165_load_n !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_load_n: got %b, required 1", bus.SN74HC165_load_n);
    end
    vectors++;
    if (bus.SN74HC165_clk !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_cp: got %b, required 0", bus.SN74HC165_clk);
    end
    vectors++;
    if (key_level !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_level: got %h, required 00", key_level);
    end
    vectors++;
    if ({key_press_pulse, key_release_pulse} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_pulses: got %h/%h, required 00/00", key_press_pulse, key_release_pulse);
    end
    vectors++;
    if (scan_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_scan_done: got %b, required 0", scan_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_waveform();
    int n;
    int lows;
    bit idle_bad;
    logic [3:0] pat;
    n = 0;
    idle_bad = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (bus.SN74HC165_load_n === 1'b1 && bus.SN74HC165_clk !== 1'b0) idle_bad = 1'b1;
    end while (bus.SN74HC165_load_n !== 1'b0 && n < 200);
    vectors++;
    if (n != ScanPer) begin
      miscompares++;
      $display("FAIL first_load_delay: got %0d cycles, required %0d", n, ScanPer);
    end
    vectors++;
    if (idle_bad) begin
      miscompares++;
      $display("FAIL idle_cp: CP toggled while idle, required 0");
    end
    lows = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.SN74HC165_load_n === 1'b0) lows++;
      else break;
    end
    vectors++;
    if (lows != ClkDiv) begin
      miscompares++;
      $display("FAIL load_width: got %0d cycles, required %0d", lows, ClkDiv);
    end
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < 4; k++) begin
        pat[k] = bus.SN74HC165_clk & bus.SN74HC165_load_n;
        @(negedge clk);
      end
      vectors++;
      if (pat !== 4'b1100) begin
        miscompares++;
        $display("FAIL cp_period%0d: got phases %b, required 1100", p, pat);
      end
    end
    vectors++;
    if ({scan_done, bus.SN74HC165_clk, bus.SN74HC165_load_n} !== 3'b101) begin
      miscompares++;
      $display("FAIL done_cycle: got done/cp/load_n=%b%b%b, required 101",
               scan_done, bus.SN74HC165_clk, bus.SN74HC165_load_n);
    end
    @(negedge clk);
    vectors++;
    if (scan_done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_width: got %b one cycle later, required 0", scan_done);
    end
  endtask

  task automatic test_bit_order();
    logic [7:0] exp_l;
    logic [7:0] exp_p;
    keys = 8'hFE;
    for (int s = 1; s <= 3; s++) begin
      exp_l = (s == 3) ? 8'h01 : 8'h00;
      exp_p = (s == 3) ? 8'h01 : 8'h00;
      next_scan();
      vectors++;
      if ({key_level, key_press_pulse, key_release_pulse} !== {exp_l, exp_p, 8'h00}) begin
        miscompares++;
        $display("FAIL bit_order_scan%0d: got lvl/prs/rel %h/%h/%h, required %h/%h/00",
                 s, key_level, key_press_pulse, key_release_pulse, exp_l, exp_p);
      end
    end
    @(negedge clk);
    vectors++;
    if ({key_level, key_press_pulse} !== {8'h01, 8'h00}) begin
      miscompares++;
      $display("FAIL bit_order_pulse_width: got lvl/prs %h/%h, required 01/00",
               key_level, key_press_pulse);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] seq_keys [6];
    logic [7:0] exp_l;
    logic [7:0] exp_p;
    seq_keys = '{8'hDE, 8'hDE, 8'hFE, 8'hDE, 8'hDE, 8'hDE};
    for (int s = 0; s < 6; s++) begin
      keys  = seq_keys[s];
      exp_l = (s == 5) ? 8'h21 : 8'h01;
      exp_p = (s == 5) ? 8'h20 : 8'h00;
      next_scan();
      vectors++;
      if ({key_level, key_press_pulse, key_release_pulse} !== {exp_l, exp_p, 8'h00}) begin
        miscompares++;
        $display("FAIL glitch_scan%0d: got lvl/prs/rel %h/%h/%h, required %h/%h/00",
                 s, key_level, key_press_pulse, key_release_pulse, exp_l, exp_p);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0]  seq_keys [6];
    logic [23:0] seq_exp  [6];
    seq_keys = '{8'h7E, 8'h7E, 8'h7E, 8'hFF, 8'hFF, 8'hFF};
    seq_exp  = '{24'h21_00_00, 24'h21_00_00, 24'h81_80_20,
                 24'h81_00_00, 24'h81_00_00, 24'h00_00_81};
    for (int s = 0; s < 6; s++) begin
      keys = seq_keys[s];
      next_scan();
      vectors++;
      if ({key_level, key_press_pulse, key_release_pulse} !== seq_exp[s]) begin
        miscompares++;
        $display("FAIL simul_scan%0d: got lvl/prs/rel %h/%h/%h, required %h",
                 s, key_level, key_press_pulse, key_release_pulse, seq_exp[s]);
      end
    end
    @(negedge clk);
    vectors++;
    if ({key_level, key_press_pulse, key_release_pulse} !== 24'h0) begin
      miscompares++;
      $display("FAIL release_pulse_width: got lvl/prs/rel %h/%h/%h, required 00/00/00",
               key_level, key_press_pulse, key_release_pulse);
    end
  endtask

  task automatic test_reset_mid_shift();
    int n;
    keys = 8'hFE;
    for (int s = 0; s < 3; s++) next_scan();
    vectors++;
    if (key_level !== 8'h01) begin
      miscompares++;
      $display("FAIL pre_reset_level: got %h, required 01", key_level);
    end
    n = 0;
    while (bus.SN74HC165_load_n !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    while (bus.SN74HC165_load_n !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    // Now at bit 7 phase 0; step to bit 4 phase 2 (CP high).
    repeat (3 * ClkDiv + 2) @(negedge clk);
    vectors++;
    if (bus.SN74HC165_clk !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_cp: got %b at bit4 phase2, required 1", bus.SN74HC165_clk);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.SN74HC165_load_n, bus.SN74HC165_clk, scan_done} !== 3'b100) begin
      miscompares++;
      $display("FAIL mid_reset_pins: got load_n/cp/done %b%b%b, required 100",
               bus.SN74HC165_load_n, bus.SN74HC165_clk, scan_done);
    end
    vectors++;
    if ({key_level, key_press_pulse, key_release_pulse} !== 24'h0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got lvl/prs/rel %h/%h/%h, required 00/00/00",
               key_level, key_press_pulse, key_release_pulse);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      next_scan();
      vectors++;
      if ({key_level, key_press_pulse, key_release_pulse} !==
          ((s == 3) ? 24'h01_01_00 : 24'h0)) begin
        miscompares++;
        $display("FAIL post_reset_scan%0d: got lvl/prs/rel %h/%h/%h, required %s",
                 s, key_level, key_press_pulse, key_release_pulse,
                 (s == 3) ? "01/01/00" : "00/00/00");
      end
    end
  endtask

  initial begin
    test_reset();
    test_waveform();
    test_bit_order();
    test_glitch();
    test_simultaneous();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
